uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Sequences the UART oversampling sampler to receive one asynchronous serial frame.
//  Detects the start edge on the serial line and launches one sampler window per bit.
//  Collects the majority-voted bits LSB-first, checks optional parity and the stop bit,
//  then presents the byte with status strobes. Sits between the RX pin synchronizer and
//  the sampler on one side, and the receive FIFO/consumer on the other.
// PARAMETERS
//  DATA_BITS   8    data bits per frame (5..9)
//  PARITY_EN   0    1 = one parity bit follows the data bits
//  PARITY_ODD  0    1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//  OVERSAMPLE  16   ticks per bit; bit-window timeout = 2*OVERSAMPLE ticks
// PORTS
//  clk         in   1          system clock
//  rst         in   1          reset, asynchronous, active-low
//  rx          in   1          serial line, already synchronized to clk, idle high
//  tick        in   1          1-cycle strobe at OVERSAMPLE x baud rate
//  smp_go      out  1          1-cycle pulse: restart sampler window for next bit
//  smp_bit     in   1          sampler majority-voted bit value
//  smp_valid   in   1          1-cycle strobe: smp_bit is valid for current window
//  data        out  DATA_BITS  received data, LSB = first bit on line
//  data_valid  out  1          1-cycle strobe: data/parity_err/frame_err valid
//  parity_err  out  1          parity mismatch (meaningful only with data_valid)
//  frame_err   out  1          stop bit low or bit-window timeout
//  busy        out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset (rst low, async): state IDLE, armed=0, data=0, all strobes/flags 0, counters 0.
//  All outputs registered; strobes high for exactly one clk.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: armed set when rx==1 sampled on a tick. If armed and rx==0 on a tick:
//   smp_go=1 next cycle, clear bit_cnt/tick_cnt, go START.
//  Bit states wait for smp_valid; on smp_valid evaluate smp_bit, pulse smp_go (unless
//   leaving to IDLE), clear tick_cnt.
//  START: smp_bit=1 -> false start: IDLE, no strobes, armed stays 1. smp_bit=0 -> DATA.
//  DATA: shift reg <= {smp_bit, shift[DATA_BITS-1:1]}; running parity ^= smp_bit;
//   bit_cnt++; at bit_cnt==DATA_BITS-1 go PARITY if PARITY_EN else STOP.
//  PARITY: parity_bad = (parity ^ smp_bit) != PARITY_ODD; go STOP.
//  STOP: next cycle data=shift, data_valid=1, parity_err=parity_bad&PARITY_EN,
//   frame_err=~smp_bit; go IDLE. If smp_bit=0 (break), armed cleared: no new start
//   until rx seen high. Latency: data_valid 1 clk after the STOP smp_valid.
//  Timeout: tick_cnt counts ticks in bit states; reaching 2*OVERSAMPLE without smp_valid
//   -> IDLE, frame_err=1 with data_valid=0, armed=0.
//  smp_valid and tick same cycle: smp_valid wins; tick_cnt clears, not incremented.
//  smp_valid in IDLE: ignored. tick=0 forever: IDLE never leaves, no timeout.
//  data holds last frame until next data_valid; parity_err/frame_err hold likewise.
//  Widths: bit_cnt clog2(DATA_BITS)+1 bits, tick_cnt clog2(2*OVERSAMPLE)+1 bits; no wrap.
//  Reset mid-frame: immediate abort to IDLE, no strobe emitted, partial byte discarded.
// TESTING
//  1. 8N1, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1 -> data=0xA5,
//     data_valid 1 clk, parity_err=0, frame_err=0, 10 smp_go pulses total.
//  2. PARITY_EN=1, even, send 0x03 with parity bit 1 -> data=0x03, parity_err=1;
//     resend with parity 0 -> parity_err=0.
//  3. START window returns smp_bit=1 -> back to IDLE, busy=0, no data_valid.
//  4. Stop bit 0 (break, rx held low) -> data_valid=1, frame_err=1; hold rx low 40 ticks:
//     no new frame; raise rx, send 0x5A -> received cleanly.
//  5. Withhold smp_valid in DATA for 32 ticks -> frame_err=1, data_valid=0, busy=0.
//  6. Assert rst low mid-DATA -> all outputs 0 immediately; after release, 0xFF received.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_if.sv
// Bundle between the UART RX frame controller, its pin/sampler front end and the consumer.
// Signal prefixes are from the frame controller's point of view.
interface uart_rx_frame_ctrl_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_rx;
   logic                 i_tick;
   logic                 o_smp_go;
   logic                 i_smp_bit;
   logic                 i_smp_valid;
   logic [DATA_BITS-1:0] o_data;
   logic                 o_data_valid;
   logic                 o_parity_err;
   logic                 o_frame_err;
   logic                 o_busy;

   modport slave (
      input  i_rx, i_tick, i_smp_bit, i_smp_valid,
      output o_smp_go, o_data, o_data_valid, o_parity_err, o_frame_err, o_busy
   );

   modport master (
      output i_rx, i_tick, i_smp_bit, i_smp_valid,
      input  o_smp_go, o_data, o_data_valid, o_parity_err, o_frame_err, o_busy
   );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: start detection, per-bit sampler launch, LSB-first
// assembly, optional parity and stop-bit checking, bit-window timeout.
module uart_rx_frame_ctrl #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int OVERSAMPLE = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   uart_rx_frame_ctrl_if.slave    bus
);
   localparam int BCW = $clog2(DATA_BITS) + 1;
   localparam int TCW = $clog2(2 * OVERSAMPLE) + 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
   localparam logic [TCW-1:0] TMO      = TCW'(2 * OVERSAMPLE);
   localparam logic           PAR_EN   = 1'(PARITY_EN);
   localparam logic           PAR_ODD  = 1'(PARITY_ODD);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]           r_state;
   logic                 r_armed;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic                 r_parity_bad;
   logic [BCW-1:0]       r_bit_cnt;
   logic [TCW-1:0]       r_tick_cnt;
   logic                 r_smp_go;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_data_valid;
   logic                 r_parity_err;
   logic                 r_frame_err;
   logic                 r_busy;
   logic [TCW-1:0]       w_tick_inc;

   assign w_tick_inc = r_tick_cnt + TCW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_armed      <= 1'b0;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_parity_bad <= 1'b0;
         r_bit_cnt    <= '0;
         r_tick_cnt   <= '0;
         r_smp_go     <= 1'b0;
         r_data       <= '0;
         r_data_valid <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_smp_go     <= 1'b0;
         r_data_valid <= 1'b0;
         if (r_state == IDLE) begin
            // A start edge is only honoured after the line has been seen idle-high.
            if (bus.i_tick) begin
               if (bus.i_rx) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_state      <= START;
                  r_busy       <= 1'b1;
                  r_smp_go     <= 1'b1;
                  r_bit_cnt    <= '0;
                  r_tick_cnt   <= '0;
                  r_parity     <= 1'b0;
                  r_parity_bad <= 1'b0;
               end
            end
         end else if (bus.i_smp_valid) begin
            r_tick_cnt <= '0;
            case (r_state)
               START: begin
                  if (bus.i_smp_bit) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state  <= DATA;
                     r_smp_go <= 1'b1;
                  end
               end
               DATA: begin
                  r_shift   <= {bus.i_smp_bit, r_shift[DATA_BITS-1:1]};
                  r_parity  <= r_parity ^ bus.i_smp_bit;
                  r_bit_cnt <= r_bit_cnt + BCW'(1);
                  r_smp_go  <= 1'b1;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_state <= PAR_EN ? PARITY : STOP;
                  end
               end
               PARITY: begin
                  r_parity_bad <= (r_parity ^ bus.i_smp_bit) != PAR_ODD;
                  r_state      <= STOP;
                  r_smp_go     <= 1'b1;
               end
               STOP: begin
                  r_data       <= r_shift;
                  r_data_valid <= 1'b1;
                  r_parity_err <= r_parity_bad & PAR_EN;
                  r_frame_err  <= ~bus.i_smp_bit;
                  // A low stop bit means break: wait for the line to return high.
                  if (!bus.i_smp_bit) begin
                     r_armed <= 1'b0;
                  end
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end else if (bus.i_tick) begin
            if (w_tick_inc == TMO) begin
               r_state     <= IDLE;
               r_busy      <= 1'b0;
               r_frame_err <= 1'b1;
               r_armed     <= 1'b0;
               r_tick_cnt  <= '0;
            end else begin
               r_tick_cnt <= w_tick_inc;
            end
         end
      end
   end

   assign bus.o_smp_go     = r_smp_go;
   assign bus.o_data       = r_data;
   assign bus.o_data_valid = r_data_valid;
   assign bus.o_parity_err = r_parity_err;
   assign bus.o_frame_err  = r_frame_err;
   assign bus.o_busy       = r_busy;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench: an 8N1 and an 8E1 instance share the stimulus, one selected at a time.
module tb_uart_rx_frame_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic sel = 1'b0;
   logic rx = 1'b1;
   logic tick = 1'b0;
   logic smp_bit = 1'b0;
   logic smp_valid = 1'b0;

   uart_rx_frame_ctrl_if #(.DATA_BITS(8)) if0 ();
   uart_rx_frame_ctrl_if #(.DATA_BITS(8)) if1 ();

   assign if0.i_rx        = sel ? 1'b1 : rx;
   assign if1.i_rx        = sel ? rx : 1'b1;
   assign if0.i_tick      = tick;
   assign if1.i_tick      = tick;
   assign if0.i_smp_bit   = smp_bit;
   assign if1.i_smp_bit   = smp_bit;
   assign if0.i_smp_valid = smp_valid & ~sel;
   assign if1.i_smp_valid = smp_valid & sel;

   uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(16))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLE(16))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   wire       w_go   = sel ? if1.o_smp_go     : if0.o_smp_go;
   wire       w_dv   = sel ? if1.o_data_valid : if0.o_data_valid;
   wire       w_busy = sel ? if1.o_busy       : if0.o_busy;
   wire       w_fe   = sel ? if1.o_frame_err  : if0.o_frame_err;
   wire       w_pe   = sel ? if1.o_parity_err : if0.o_parity_err;
   wire [7:0] w_data = sel ? if1.o_data       : if0.o_data;

   int errors = 0;
   int checks = 0;
   int go_cnt = 0;
   int dv_cnt = 0;
   logic [7:0] cap_data = '0;
   logic       cap_pe = 1'b0;
   logic       cap_fe = 1'b0;

   always @(negedge clk) begin
      if (w_go) go_cnt <= go_cnt + 1;
      if (w_dv) begin
         dv_cnt   <= dv_cnt + 1;
         cap_data <= w_data;
         cap_pe   <= w_pe;
         cap_fe   <= w_fe;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
   endtask

   task automatic launch(input bit arm);
      if (arm) begin
         rx = 1'b1;
         pulse_tick();
      end
      rx = 1'b0;
      pulse_tick();
   endtask

   task automatic send_bit(input bit b);
      smp_bit   = b;
      smp_valid = 1'b1;
      step();
      smp_valid = 1'b0;
      repeat (2) step();
   endtask

   task automatic body(input logic [7:0] d, input bit par_en, input bit par_bit, input bit stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (par_en) send_bit(par_bit);
      send_bit(stop);
      if (stop) rx = 1'b1;
      repeat (2) step();
   endtask

   typedef struct {
      bit         sel;
      logic [7:0] d;
      bit         par_bit;
      logic [7:0] exp_data;
      bit         exp_pe;
      int         exp_go;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int g0, v0;
      vecs[0] = '{sel: 1'b0, d: 8'hA5, par_bit: 1'b0, exp_data: 8'hA5, exp_pe: 1'b0, exp_go: 10};
      vecs[1] = '{sel: 1'b1, d: 8'h03, par_bit: 1'b1, exp_data: 8'h03, exp_pe: 1'b1, exp_go: 11};
      vecs[2] = '{sel: 1'b1, d: 8'h03, par_bit: 1'b0, exp_data: 8'h03, exp_pe: 1'b0, exp_go: 11};
      vecs[3] = '{sel: 1'b1, d: 8'h07, par_bit: 1'b1, exp_data: 8'h07, exp_pe: 1'b0, exp_go: 11};
      vecs[4] = '{sel: 1'b0, d: 8'h96, par_bit: 1'b0, exp_data: 8'h96, exp_pe: 1'b0, exp_go: 10};

      #2 rst_n = 1'b0;
      repeat (3) step();
      chk("reset_dut0", {if0.o_busy, if0.o_data_valid, if0.o_parity_err, if0.o_frame_err,
                         if0.o_smp_go, if0.o_data}, 32'h0);
      chk("reset_dut1", {if1.o_busy, if1.o_data_valid, if1.o_parity_err, if1.o_frame_err,
                         if1.o_smp_go, if1.o_data}, 32'h0);
      rst_n = 1'b1;
      step();

      for (int k = 0; k < 5; k++) begin
         sel = vecs[k].sel;
         step();
         g0 = go_cnt;
         v0 = dv_cnt;
         launch(1'b1);
         body(vecs[k].d, vecs[k].sel, vecs[k].par_bit, 1'b1);
         $display("vec %0d sel=%0d data=%02h dv=%0d pe=%0d fe=%0d go=%0d", k, sel, cap_data,
                  dv_cnt - v0, cap_pe, cap_fe, go_cnt - g0);
         chk($sformatf("vec%0d_dv_count", k), dv_cnt - v0, 1);
         chk($sformatf("vec%0d_data", k), cap_data, vecs[k].exp_data);
         chk($sformatf("vec%0d_parity_err", k), cap_pe, vecs[k].exp_pe);
         chk($sformatf("vec%0d_frame_err", k), cap_fe, 0);
         chk($sformatf("vec%0d_smp_go", k), go_cnt - g0, vecs[k].exp_go);
         chk($sformatf("vec%0d_busy", k), w_busy, 0);
      end

      // False start keeps the receiver armed.
      sel = 1'b0;
      step();
      g0 = go_cnt;
      v0 = dv_cnt;
      launch(1'b1);
      send_bit(1'b1);
      $display("false start busy=%0d dv=%0d go=%0d", w_busy, dv_cnt - v0, go_cnt - g0);
      chk("false_start_busy", w_busy, 0);
      chk("false_start_dv", dv_cnt - v0, 0);
      chk("false_start_go", go_cnt - g0, 1);
      launch(1'b0);
      chk("rearm_after_false_start", w_busy, 1);
      body(8'hC3, 1'b0, 1'b0, 1'b1);
      $display("after false start data=%02h fe=%0d", cap_data, cap_fe);
      chk("after_false_start_data", cap_data, 8'hC3);

      // Break: stop bit low, line held low, then recovery.
      v0 = dv_cnt;
      launch(1'b1);
      body(8'h3C, 1'b0, 1'b0, 1'b0);
      $display("break data=%02h dv=%0d fe=%0d", cap_data, dv_cnt - v0, cap_fe);
      chk("break_dv", dv_cnt - v0, 1);
      chk("break_frame_err", cap_fe, 1);
      chk("break_data", cap_data, 8'h3C);
      g0 = go_cnt;
      v0 = dv_cnt;
      repeat (40) pulse_tick();
      $display("break hold go=%0d busy=%0d", go_cnt - g0, w_busy);
      chk("break_hold_go", go_cnt - g0, 0);
      chk("break_hold_busy", w_busy, 0);
      launch(1'b1);
      body(8'h5A, 1'b0, 1'b0, 1'b1);
      $display("post break data=%02h dv=%0d fe=%0d", cap_data, dv_cnt - v0, cap_fe);
      chk("post_break_dv", dv_cnt - v0, 1);
      chk("post_break_data", cap_data, 8'h5A);
      chk("post_break_frame_err", cap_fe, 0);

      // Bit-window timeout in DATA.
      v0 = dv_cnt;
      launch(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      repeat (31) pulse_tick();
      chk("timeout_not_yet_busy", w_busy, 1);
      chk("timeout_not_yet_fe", w_fe, 0);
      pulse_tick();
      $display("timeout busy=%0d fe=%0d dv=%0d", w_busy, w_fe, dv_cnt - v0);
      chk("timeout_busy", w_busy, 0);
      chk("timeout_frame_err", w_fe, 1);
      chk("timeout_dv", dv_cnt - v0, 0);
      rx = 1'b1;
      step();

      // Asynchronous reset mid-DATA.
      launch(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      #2 rst_n = 1'b0;
      #1;
      $display("mid-frame reset busy=%0d data=%02h fe=%0d", if0.o_busy, if0.o_data, if0.o_frame_err);
      chk("midreset_outputs", {if0.o_busy, if0.o_data_valid, if0.o_parity_err, if0.o_frame_err,
                               if0.o_smp_go, if0.o_data}, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      g0 = go_cnt;
      v0 = dv_cnt;
      launch(1'b1);
      body(8'hFF, 1'b0, 1'b0, 1'b1);
      $display("post reset data=%02h dv=%0d go=%0d", cap_data, dv_cnt - v0, go_cnt - g0);
      chk("post_reset_dv", dv_cnt - v0, 1);
      chk("post_reset_data", cap_data, 8'hFF);
      chk("post_reset_go", go_cnt - g0, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
